instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of `decode`.
- Accepts symbolic instructions: an `opcode_out_t` operation, register indices and a signed immediate.
- Range-checks the fields, packs a 32-bit machine word and emits it with a sequential byte address.
- Feeds the instruction-memory loader in the test harness, and lets the self-checking bench round-trip encode→`decode`.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word after reset or restart.
- ERR_CNT_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- restart  input  1  synchronous; returns the address counter to BASE_ADDR and clears err_count.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_op  input  opcode_out_t  operation to encode.
- in_rd  input  5  destination register index.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- in_imm  input  32  signed immediate, or shift amount / upper-immediate field.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer ready.
- out_instr  output  32  encoded instruction word.
- out_addr  output  32  byte address of out_instr.
- err_pulse  output  1  one-cycle pulse: the request accepted last cycle was illegal and dropped.
- err_count  output  ERR_CNT_W  saturating count of dropped requests.

Behaviour:
- **Reset** (rst_n=0, asynchronous): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_count=0, internal next_addr=BASE_ADDR.
- **Handshake:**
  - in_ready = !out_valid || out_ready (single output register, no bubble).
  - Outputs are held stable while out_valid && !out_ready.
- **Latency:** a legal request accepted in cycle N appears with out_valid=1 in cycle N+1.
- **Legal accept:**
  - out_instr is loaded with the encoding; out_addr is loaded with next_addr; next_addr += 4.
  - next_addr wraps modulo 2^32.
- **Illegal accept:**
  - Nothing is emitted and next_addr is unchanged.
  - out_valid drops to 0 if the previous word is consumed that cycle.
  - err_pulse=1 the following cycle; err_count increments and saturates at all-ones.
- **Encodings** (standard RV32I fields):
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - funct7 = 0100000 for SUB and SRA, otherwise 0.
  - I-ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
    - in_imm must be in the range -2048..2047.
  - Shifts: SLLI, SRLI, SRAI.
    - in_imm must be in the range 0..31.
    - imm[11:5] = 0100000 for SRAI, otherwise 0.
  - Loads LB, LH, LW, LBU, LHU and JALR: I-format; in_imm must be in the range -2048..2047.
  - Stores SB, SH, SW: S-format; same immediate range; in_rd is ignored.
  - Branches BEQ, BNE, BLT, BGE, BLTU, BGEU: B-format.
    - in_imm must be in the range -4096..4094 and even.
    - in_rd is ignored.
  - JAL: J-format.
    - in_imm must be in the range -1048576..1048574 and even.
  - LUI, AUIPC: in_imm[19:0] goes to instr[31:12]; in_imm[31:20] must be 0.
  - Fields not used by a format are driven 0.
- **Illegal conditions:** an immediate out of range or odd where evenness is required, or any in_op outside the lists above.
- **restart:**
  - Takes effect at the clock edge: next_addr=BASE_ADDR, err_count=0.
  - A word already held in the output stays valid with its original address.
  - A request accepted in the same cycle as restart receives address BASE_ADDR, and next_addr becomes BASE_ADDR+4.
  - If that request is illegal, err_count = 1.
- **Simultaneous consume and accept:** out_ready && out_valid && in_valid in the same cycle replaces the output word with no bubble.
- **Reset mid-stream:** the pending output word is discarded and the address counter returns to BASE_ADDR.

Test Plan:
- Five legal requests back-to-back, with out_ready held 1 -> words appear at addresses 0x0,0x4,0x8,0xC,0x10, one per cycle with no gaps:
  - ADDI rd5 rs1 6 imm 42 -> 02A30293.
  - ADD rd1 rs1 2 rs2 3 -> 003100B3.
  - LW rd10 rs1 2 imm 16 -> 01012503.
  - BEQ rs1 1 rs2 2 imm 12 -> 00208663.
  - LUI rd3 imm 0xABCDE -> ABCDE1B7.
- SUB rd1 rs1 2 rs2 3, then SRAI rd1 rs1 1 imm 3:
  - Required words: 403100B3 and 4030D093.
  - Round-trip each emitted word through `decode`: it must report SUB then SRAI, with matching register indices.
- Out-of-range ADDI imm 2048, then odd BEQ imm 7, then ADDI imm -1 (x0,x0) -> err_pulse twice, err_count=2, only FFF00013 is emitted, at the next sequential address.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable; on release the queued request is emitted the next cycle.
- Assert restart with a legal request accepted in the same cycle -> that word gets BASE_ADDR; err_count=0.
- Drop rst_n asynchronously while out_valid=1 -> out_valid=0 immediately with no clock edge; the next emitted word gets BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder.
// Takes a symbolic instruction (operation, register indices, signed immediate),
// range-checks the fields and packs a 32-bit machine word. Each legal word is
// emitted with the next sequential byte address. Illegal requests are dropped
// and counted.

package instr_encoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_JALR,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_LUI, OP_AUIPC
  } opcode_out_t;

endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  opcode_out_t          in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U
  } fmt_t;

  // Inclusive signed range test on the immediate.
  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Saturating increment: sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic signed [31:0]   imm_s;
  fmt_t                 fmt;
  logic [6:0]           opc;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic                 op_ok;
  logic                 imm_ok;
  logic                 legal_p0;
  logic [31:0]          enc_p0;
  logic                 accept;
  logic [31:0]          addr_sel;

  logic                 vld_p1;
  logic [31:0]          instr_p1;
  logic [31:0]          addr_p1;
  logic [31:0]          next_addr;
  logic                 err_pulse_p1;
  logic [ERR_CNT_W-1:0] err_cnt_p1;

  assign imm_s    = $signed(in_imm);
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign addr_sel = restart ? BASE_ADDR : next_addr;

  // ---- p0: classify the operation and check the immediate ----

  // Map each operation to its format, major opcode and function fields.
  always_comb begin
    fmt   = FMT_R;
    opc   = 7'b0000000;
    f3    = 3'b000;
    f7    = 7'b0000000;
    op_ok = 1'b1;
    case (in_op)
      OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; end
      OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b000; f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b001; end
      OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b010; end
      OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b011; end
      OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b100; end
      OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; end
      OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b101; f7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b110; end
      OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;     f3 = 3'b111; end
      OP_ADDI:  begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b000; end
      OP_SLTI:  begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b010; end
      OP_SLTIU: begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b011; end
      OP_XORI:  begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b100; end
      OP_ORI:   begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b110; end
      OP_ANDI:  begin fmt = FMT_I;  opc = OPC_IMM;    f3 = 3'b111; end
      OP_SLLI:  begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'b001; end
      OP_SRLI:  begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'b101; end
      OP_SRAI:  begin fmt = FMT_SH; opc = OPC_IMM;    f3 = 3'b101; f7 = F7_ALT; end
      OP_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b000; end
      OP_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b001; end
      OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b010; end
      OP_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b100; end
      OP_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = 3'b101; end
      OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = 3'b000; end
      OP_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b000; end
      OP_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b001; end
      OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = 3'b010; end
      OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b000; end
      OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b001; end
      OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b100; end
      OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b101; end
      OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b110; end
      OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = 3'b111; end
      OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;    end
      OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;    end
      OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC;  end
      default:  op_ok = 1'b0;
    endcase
  end

  // Pack the word for the selected format and validate its immediate.
  always_comb begin
    enc_p0 = '0;
    imm_ok = 1'b0;
    case (fmt)
      FMT_R: begin
        imm_ok = 1'b1;
        enc_p0 = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      end
      FMT_I: begin
        imm_ok = in_range(imm_s, -32'sd2048, 32'sd2047);
        enc_p0 = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      end
      FMT_SH: begin
        // Shift amount sits in imm[4:0]; f7 supplies imm[11:5].
        imm_ok = in_range(imm_s, 32'sd0, 32'sd31);
        enc_p0 = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      end
      FMT_S: begin
        imm_ok = in_range(imm_s, -32'sd2048, 32'sd2047);
        enc_p0 = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      end
      FMT_B: begin
        imm_ok = in_range(imm_s, -32'sd4096, 32'sd4094) && !in_imm[0];
        enc_p0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                  in_imm[4:1], in_imm[11], opc};
      end
      FMT_J: begin
        imm_ok = in_range(imm_s, -32'sd1048576, 32'sd1048574) && !in_imm[0];
        enc_p0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      end
      FMT_U: begin
        // The upper-immediate value is given already shifted down by 12.
        imm_ok = (in_imm[31:20] == 12'h000);
        enc_p0 = {in_imm[19:0], in_rd, opc};
      end
      default: imm_ok = 1'b0;
    endcase
    legal_p0 = op_ok && imm_ok;
  end

  // ---- p1: output register, address counter and error tracking ----

  // Load legal words with the next address; drop and count illegal ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      instr_p1     <= '0;
      addr_p1      <= BASE_ADDR;
      next_addr    <= BASE_ADDR;
      err_pulse_p1 <= 1'b0;
      err_cnt_p1   <= '0;
    end else begin
      err_pulse_p1 <= accept && !legal_p0;

      if (accept && legal_p0) begin
        vld_p1    <= 1'b1;
        instr_p1  <= enc_p0;
        addr_p1   <= addr_sel;
        next_addr <= addr_sel + 32'd4;
      end else begin
        // An illegal accept implies the held word is gone or being consumed.
        if (accept || out_ready) vld_p1 <= 1'b0;
        if (restart) next_addr <= BASE_ADDR;
      end

      if (restart) begin
        err_cnt_p1 <= (accept && !legal_p0) ? CNT_ONE : '0;
      end else if (accept && !legal_p0) begin
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;
  assign err_pulse = err_pulse_p1;
  assign err_count = err_cnt_p1;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a transaction-level model.

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          ECW  = 3;
  localparam int          ERR_MAX = (1 << ECW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            restart = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  opcode_out_t     in_op = OP_ADD;
  logic [4:0]      in_rd = '0;
  logic [4:0]      in_rs1 = '0;
  logic [4:0]      in_rs2 = '0;
  logic [31:0]     in_imm = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_instr;
  logic [31:0]     out_addr;
  logic            err_pulse;
  logic [ECW-1:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // funct3 tables of the RV32I groups, in the package's enumeration order
  int r_f3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int i_f3  [6]  = '{0, 2, 3, 4, 6, 7};
  int sh_f3 [3]  = '{1, 5, 5};
  int ld_f3 [5]  = '{0, 1, 2, 4, 5};
  int st_f3 [3]  = '{0, 1, 2};
  int br_f3 [6]  = '{0, 1, 4, 5, 6, 7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic.
  function automatic void model_enc(input int op, input int rd, input int rs1,
                                    input int rs2, input int imm,
                                    output bit ok, output int unsigned w);
    int unsigned u, regs_i, regs_s;
    ok = 0;
    w  = 0;
    regs_i = (rs1 << 15) | (rd << 7);
    regs_s = (rs2 << 20) | (rs1 << 15);
    if (op >= int'(OP_ADD) && op <= int'(OP_AND)) begin
      int i = op - int'(OP_ADD);
      int f7 = (op == int'(OP_SUB) || op == int'(OP_SRA)) ? 32 : 0;
      ok = 1;
      w = (f7 << 25) | regs_s | regs_i | (r_f3[i] << 12) | 'h33;
    end else if (op >= int'(OP_ADDI) && op <= int'(OP_ANDI)) begin
      ok = (imm >= -2048 && imm <= 2047);
      u = imm & 'hFFF;
      w = (u << 20) | regs_i | (i_f3[op - int'(OP_ADDI)] << 12) | 'h13;
    end else if (op >= int'(OP_SLLI) && op <= int'(OP_SRAI)) begin
      ok = (imm >= 0 && imm <= 31);
      u = (imm & 31) + ((op == int'(OP_SRAI)) ? 1024 : 0);
      w = (u << 20) | regs_i | (sh_f3[op - int'(OP_SLLI)] << 12) | 'h13;
    end else if (op >= int'(OP_LB) && op <= int'(OP_LHU)) begin
      ok = (imm >= -2048 && imm <= 2047);
      u = imm & 'hFFF;
      w = (u << 20) | regs_i | (ld_f3[op - int'(OP_LB)] << 12) | 'h03;
    end else if (op == int'(OP_JALR)) begin
      ok = (imm >= -2048 && imm <= 2047);
      u = imm & 'hFFF;
      w = (u << 20) | regs_i | 'h67;
    end else if (op >= int'(OP_SB) && op <= int'(OP_SW)) begin
      ok = (imm >= -2048 && imm <= 2047);
      u = imm & 'hFFF;
      w = ((u / 32) << 25) | regs_s | (st_f3[op - int'(OP_SB)] << 12) | ((u % 32) << 7) | 'h23;
    end else if (op >= int'(OP_BEQ) && op <= int'(OP_BGEU)) begin
      ok = (imm >= -4096 && imm <= 4094 && (imm % 2) == 0);
      u = imm & 'h1FFF;
      w = ((u / 4096) << 31) | (((u / 32) % 64) << 25) | regs_s |
          (br_f3[op - int'(OP_BEQ)] << 12) | (((u / 2) % 16) << 8) |
          (((u / 2048) % 2) << 7) | 'h63;
    end else if (op == int'(OP_JAL)) begin
      ok = (imm >= -1048576 && imm <= 1048574 && (imm % 2) == 0);
      u = imm & 'h1FFFFF;
      w = ((u / 1048576) << 31) | (((u / 2) % 1024) << 21) | (((u / 2048) % 2) << 20) |
          (((u / 4096) % 256) << 12) | (rd << 7) | 'h6F;
    end else if (op == int'(OP_LUI) || op == int'(OP_AUIPC)) begin
      ok = (imm >= 0 && imm < 1048576);
      w = ((imm & 'hFFFFF) << 12) | (rd << 7) | ((op == int'(OP_LUI)) ? 'h37 : 'h17);
    end
  endfunction

  // Small decoder for register-register and register-immediate ALU words.
  function automatic int decode(input logic [31:0] w);
    int opc, f3, f7;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    if (opc == 'h33) begin
      for (int i = 0; i < 10; i++)
        if (r_f3[i] == f3 && f7 == ((i == 1 || i == 7) ? 32 : 0)) return int'(OP_ADD) + i;
    end else if (opc == 'h13) begin
      if (f3 == 1 && f7 == 0) return int'(OP_SLLI);
      if (f3 == 5 && f7 == 0) return int'(OP_SRLI);
      if (f3 == 5 && f7 == 32) return int'(OP_SRAI);
      for (int i = 0; i < 6; i++)
        if (i_f3[i] == f3) return int'(OP_ADDI) + i;
    end
    return -1;
  endfunction

  // Transaction-level model state
  bit          m_vld = 0;
  int unsigned m_instr = 0;
  int unsigned m_addr = BASE;
  int unsigned m_next = BASE;
  bit          m_errp = 0;
  int          m_errc = 0;

  // Model: consume, then (restart), then accept a new request if there was room.
  always @(posedge clk or negedge rst_n) begin
    bit acc, ok;
    int unsigned w;
    if (!rst_n) begin
      m_vld = 0; m_instr = 0; m_addr = BASE; m_next = BASE; m_errp = 0; m_errc = 0;
    end else begin
      acc = in_valid && (!m_vld || out_ready);
      if (m_vld && out_ready) m_vld = 0;
      if (restart) begin
        m_next = BASE;
        m_errc = 0;
      end
      m_errp = 0;
      if (acc) begin
        model_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm), ok, w);
        if (ok) begin
          m_vld = 1; m_instr = w; m_addr = m_next; m_next = m_next + 4;
        end else begin
          m_errp = 1;
          if (m_errc < ERR_MAX) m_errc++;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
      chk("err_pulse", 32'(err_pulse), 32'(m_errp));
      chk("err_count", 32'(err_count), 32'(m_errc));
      if (m_vld) begin
        chk("out_instr", out_instr, m_instr);
        chk("out_addr", out_addr, m_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input opcode_out_t op, input int rd, input int rs1,
                      input int rs2, input int imm);
    in_valid = 1'b1;
    in_op  = op;
    in_rd  = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = 32'(imm);
    step();
  endtask

  function automatic int rand_imm();
    int lst [20] = '{-2049, -2048, 2047, 2048, 0, 31, 32, -1, -4096, -4097,
                     4094, 4095, 4096, -1048576, 1048574, 1048575, 1048576,
                     -1048578, 'hFFFFF, 'h100000};
    case ($urandom_range(0, 5))
      0: return int'($urandom_range(0, 80)) - 40;
      1: return int'($urandom_range(0, 4200)) - 2100;
      2: return int'($urandom_range(0, 8400)) - 4200;
      3: return int'($urandom_range(0, 2097200)) - 1048600;
      4: return lst[$urandom_range(0, 19)];
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    bit ok;
    int unsigned w;
    logic [31:0] seq_w [5] = '{32'h02A30293, 32'h003100B3, 32'h01012503,
                               32'h00208663, 32'hABCDE1B7};

    // Reset state
    step();
    chk_en = 1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    // Pin the model against hand-encoded words
    model_enc(int'(OP_ADDI), 5, 6, 0, 42, ok, w);         chk("mdl_addi", w, 32'h02A30293);
    model_enc(int'(OP_ADD), 1, 2, 3, 0, ok, w);           chk("mdl_add", w, 32'h003100B3);
    model_enc(int'(OP_LW), 10, 2, 0, 16, ok, w);          chk("mdl_lw", w, 32'h01012503);
    model_enc(int'(OP_BEQ), 0, 1, 2, 12, ok, w);          chk("mdl_beq", w, 32'h00208663);
    model_enc(int'(OP_LUI), 3, 0, 0, 'hABCDE, ok, w);     chk("mdl_lui", w, 32'hABCDE1B7);
    model_enc(int'(OP_SUB), 1, 2, 3, 0, ok, w);           chk("mdl_sub", w, 32'h403100B3);
    model_enc(int'(OP_SRAI), 1, 1, 0, 3, ok, w);          chk("mdl_srai", w, 32'h4030D093);
    model_enc(int'(OP_ADDI), 0, 0, 0, -1, ok, w);         chk("mdl_addi_m1", w, 32'hFFF00013);
    model_enc(int'(OP_ADDI), 0, 0, 0, 2048, ok, w);       chk("mdl_addi_oor", 32'(ok), 32'd0);
    model_enc(int'(OP_BEQ), 0, 1, 2, 7, ok, w);           chk("mdl_beq_odd", 32'(ok), 32'd0);

    // Five legal requests back to back
    send(OP_ADDI, 5, 6, 0, 42);
    chk("seq0_instr", out_instr, seq_w[0]); chk("seq0_addr", out_addr, 32'h0);
    send(OP_ADD, 1, 2, 3, 0);
    chk("seq1_instr", out_instr, seq_w[1]); chk("seq1_addr", out_addr, 32'h4);
    send(OP_LW, 10, 2, 0, 16);
    chk("seq2_instr", out_instr, seq_w[2]); chk("seq2_addr", out_addr, 32'h8);
    send(OP_BEQ, 0, 1, 2, 12);
    chk("seq3_instr", out_instr, seq_w[3]); chk("seq3_addr", out_addr, 32'hC);
    send(OP_LUI, 3, 0, 0, 'hABCDE);
    chk("seq4_instr", out_instr, seq_w[4]); chk("seq4_addr", out_addr, 32'h10);

    // SUB / SRAI round trip through the decoder
    send(OP_SUB, 1, 2, 3, 0);
    chk("rt_sub_word", out_instr, 32'h403100B3);
    chk("rt_sub_op", 32'(decode(out_instr)), 32'(int'(OP_SUB)));
    chk("rt_sub_rd", 32'(out_instr[11:7]), 32'd1);
    chk("rt_sub_rs1", 32'(out_instr[19:15]), 32'd2);
    chk("rt_sub_rs2", 32'(out_instr[24:20]), 32'd3);
    send(OP_SRAI, 1, 1, 0, 3);
    chk("rt_srai_word", out_instr, 32'h4030D093);
    chk("rt_srai_op", 32'(decode(out_instr)), 32'(int'(OP_SRAI)));
    chk("rt_srai_rd", 32'(out_instr[11:7]), 32'd1);
    chk("rt_srai_rs1", 32'(out_instr[19:15]), 32'd1);

    // Illegal requests are dropped and counted
    send(OP_ADDI, 1, 1, 0, 2048);
    chk("err1_pulse", 32'(err_pulse), 32'd1);
    chk("err1_valid", 32'(out_valid), 32'd0);
    send(OP_BEQ, 0, 1, 2, 7);
    chk("err2_pulse", 32'(err_pulse), 32'd1);
    send(OP_ADDI, 0, 0, 0, -1);
    chk("err3_pulse", 32'(err_pulse), 32'd0);
    chk("err3_instr", out_instr, 32'hFFF00013);
    chk("err3_addr", out_addr, 32'h1C);
    chk("err3_count", 32'(err_count), 32'd2);

    // Counter saturation
    for (int i = 0; i < 8; i++) send(opcode_out_t'(6'd63), 0, 0, 0, 0);
    chk("sat_count", 32'(err_count), 32'(ERR_MAX));

    // Backpressure: output held stable, queued request emitted on release
    send(OP_ADDI, 1, 0, 0, 1);
    chk("bp_first", out_instr, 32'h00100093);
    out_ready = 1'b0;
    in_op = OP_ADDI; in_rd = 5'd2; in_imm = 32'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_instr", out_instr, 32'h00100093);
      chk("bp_hold_addr", out_addr, 32'h20);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_instr", out_instr, 32'h00200113);
    chk("bp_release_addr", out_addr, 32'h24);
    in_valid = 1'b0;
    step();

    // Restart together with a legal accept
    restart = 1'b1;
    send(OP_ADDI, 3, 0, 0, 3);
    restart = 1'b0;
    chk("rs_addr", out_addr, BASE);
    chk("rs_instr", out_instr, 32'h00300193);
    chk("rs_count", 32'(err_count), 32'd0);
    send(OP_ADDI, 4, 0, 0, 4);
    chk("rs_next_addr", out_addr, BASE + 32'd4);
    in_valid = 1'b0;

    // Asynchronous reset while a word is held
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", out_addr, BASE);
    step();
    rst_n = 1'b1;
    send(OP_ADDI, 5, 0, 0, 5);
    chk("arst_next_addr", out_addr, BASE);
    chk("arst_next_instr", out_instr, 32'h00500293);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      restart   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 85) in_op = opcode_out_t'(6'($urandom_range(0, 36)));
      else                            in_op = opcode_out_t'(6'($urandom_range(37, 63)));
      in_rd  = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      in_imm = 32'(rand_imm());
      step();
    end
    in_valid = 1'b0;
    restart = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
